// File: rtl/flag_union_pkg.sv
// Shared types for the flag union pipe: lane/flat flag union and transform mode.
package flag_union_pkg;

   localparam int LANES  = 3;
   localparam int LANE_W = 32;
   localparam int W      = LANES * LANE_W;

   typedef union packed {
      logic [W-1:0]                  flat;
      logic [LANES-1:0][LANE_W-1:0]  lane;
   } flag_union_t;

   typedef enum logic [1:0] {
      MODE_PASS    = 2'd0,
      MODE_REVERSE = 2'd1,
      MODE_STICKY  = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_e;

endpackage

// File: rtl/flag_fifo.sv
// Circular buffer with wrap-at-DEPTH pointers (any DEPTH 1..16) and an occupancy count.
module flag_fifo #(
   parameter int W     = 96,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [W-1:0]               in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   assign in_ready  = (count_q < CNT_MAX);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_q;

   // Storage is never reset, so gate the head to keep X off out_data while empty.
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: rtl/flag_union_pipe.sv
// Flag union pipe: per-beat PASS/REVERSE/STICKY transform ahead of a small FIFO.
module flag_union_pipe
   import flag_union_pkg::*;
#(
   parameter int LANES  = 3,
   parameter int LANE_W = 32,
   parameter int DEPTH  = 2,
   localparam int W     = LANES * LANE_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 mode,
   input  logic                       clr,
   input  logic                       in_valid,
   input  logic [W-1:0]               in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       sticky_any
);

   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] acc_base;
   logic [W-1:0] rev_data;
   logic [W-1:0] store_data;
   logic         accept;
   mode_e        mode_sel;

   assign mode_sel = mode_e'(mode);
   assign accept   = in_valid & in_ready;

   for (genvar k = 0; k < LANES; k++) begin : g_rev
      assign rev_data[k*LANE_W +: LANE_W] = in_data[(LANES-1-k)*LANE_W +: LANE_W];
   end

   // Clear takes effect before a same-cycle sticky merge.
   assign acc_base = clr ? '0 : acc_q;

   always_comb begin
      store_data = in_data;
      acc_d      = acc_base;
      case (mode_sel)
         MODE_REVERSE: store_data = rev_data;
         MODE_STICKY: begin
            store_data = acc_base | in_data;
            if (accept) begin
               acc_d = acc_base | in_data;
            end
         end
         default:      store_data = in_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign sticky_any = |acc_q;

   flag_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (store_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

endmodule

// File: doc/flag_union_pipe.md
FLAG_UNION_PIPE -- requirements
Module: flag_union_pipe

Interface
REQ-001 Parameter LANES, default 3, number of flag lanes.
REQ-002 Parameter LANE_W, default 32, bits per lane.
REQ-003 Parameter DEPTH, default 2, buffer entries; legal range 1..16.
REQ-004 Derived W = LANES*LANE_W (default 96), full packed width of the flag union.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 mode  input  2  transform selected for the beat being accepted: 0 PASS, 1 REVERSE, 2 STICKY, 3 reserved (treated as PASS).
REQ-008 clr  input  1  single-cycle pulse clearing the sticky accumulator.
REQ-009 in_valid  input  1  producer holds a valid beat.
REQ-010 in_data  input  W  flag union, flat view [W-1:0], lane view [LANES-1:0][LANE_W-1:0].
REQ-011 in_ready  output  1  block can accept a beat this cycle.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_data  output  W  head entry, same union layout as in_data.
REQ-014 out_ready  input  1  consumer takes the head entry.
REQ-015 count  output  clog2(DEPTH+1)  entries held.
REQ-016 sticky_any  output  1  OR-reduction of the sticky accumulator.

Function
REQ-017 Beat accepted when in_valid and in_ready are both high at a rising edge; beat popped when out_valid and out_ready are both high.
REQ-018 in_ready = (count < DEPTH); no same-cycle pop-through when full.
REQ-019 PASS: stored value = in_data unchanged.
REQ-020 REVERSE: stored lane k = in_data lane LANES-1-k; bit order within each lane preserved.
REQ-021 STICKY: acc_next = acc | in_data; stored value = acc_next.
REQ-022 PASS and REVERSE beats leave the accumulator unchanged.
REQ-023 Transform uses mode sampled at the accept edge; stored entries are unaffected by later mode changes.
REQ-024 Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N when the buffer was empty; otherwise order is strict FIFO.
REQ-025 out_data holds its value while out_valid is high and out_ready is low.
REQ-026 Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both actions take effect.
REQ-027 Pointers wrap modulo DEPTH; non-power-of-two DEPTH supported.
REQ-028 clr without an accept: acc <= 0.
REQ-029 clr with a STICKY accept in the same cycle: clear is applied first; acc <= in_data and stored value = in_data.
REQ-030 clr does not alter entries already buffered.
REQ-031 When out_valid is 0, out_data is don't-care, but simulation shall not propagate X.

Reset
REQ-032 rst high at an edge: count = 0, pointers = 0, acc = 0, out_valid = 0, in_ready = 1 after that edge.
REQ-033 rst has priority over a push, pop or clr in the same cycle; buffered data is discarded.
REQ-034 Buffer storage is not reset.

Structure
REQ-035 Package flag_union_pkg holds the packed union type (flat and lane views), parametrised through LANES/LANE_W localparams, and the mode enum.
REQ-036 Sub-module flag_fifo (W, DEPTH) implements the storage, pointers and count; the top implements the transform and accumulator.

Verification
REQ-037 Reset, then PASS beat 96'h0000_0001_0000_0002_0000_0003 with out_ready=1 -> same value on out_data one edge later; count returns to 0.
REQ-038 REVERSE beat lanes {A,B,C} = {32'hAAAA_AAAA,32'hBBBB_BBBB,32'hCCCC_CCCC} -> out lanes {C,B,A}.
REQ-039 STICKY beats 96'h1, 96'h4, 96'h100 -> outputs 96'h1, 96'h5, 96'h105, sticky_any=1; then clr alone -> sticky_any=0.
REQ-040 out_ready=0, push three beats at DEPTH=2 -> in_ready=0 after the second accept; third beat held off; count=2; releasing out_ready drains in order.
REQ-041 clr and STICKY accept of 96'h8 together with acc=96'hF -> stored value 96'h8.
REQ-042 rst asserted with count=2 and a push pending -> count=0, out_valid=0 after the edge; no stale beat emitted afterwards.
